// File: rtl/fetch_stage.sv
//============================================================================
// Module : fetch_stage
// Brief  : RV32I instruction fetch with req/ack memory handshake, IF/ID
//          register, one-entry stall skid and stale-fetch discard.
//          Optional FETCH_MISALIGN_CHECK_EN adds o_misalign.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_pc_sel,
   input  logic        i_jump,
   input  logic [31:0] i_alu_data,
   input  logic        i_stall,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic [31:0] i_imem_rdata,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_four,
   output logic [31:0] o_instr,
`ifdef FETCH_MISALIGN_CHECK_EN
   output logic        o_misalign,
`endif
   output logic        o_instr_vld
);

   localparam logic [1:0] S_FETCH = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;
   localparam logic [1:0] S_DROP  = 2'd3;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] r_saved_tgt;
   logic [31:0] r_skid_pc;
   logic [31:0] r_skid_instr;
   logic [31:0] r_if_pc;
   logic [31:0] r_if_instr;
   logic        r_if_vld;
   logic        w_redirect;
   logic [31:0] w_target;
   logic        w_req;

   assign w_redirect = i_pc_sel | i_jump;

`ifdef FETCH_MISALIGN_CHECK_EN
   assign w_target = {i_alu_data[31:2], 2'b00};

   logic r_misalign;

   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_misalign <= 1'b0;
      else
         r_misalign <= w_redirect & (|i_alu_data[1:0]);
   end

   assign o_misalign = r_misalign;
`else
   assign w_target = i_alu_data;
`endif

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset)
         r_state <= S_FETCH;
      else
         r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_FETCH: begin
            if (!w_redirect && !i_stall && !i_imem_ack)
               w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (i_imem_ack) begin
               if (w_redirect || !i_stall)
                  w_state_nxt = S_FETCH;
               else
                  w_state_nxt = S_HOLD;
            end else if (w_redirect) begin
               w_state_nxt = S_DROP;
            end
         end
         S_HOLD: begin
            if (w_redirect || !i_stall)
               w_state_nxt = S_FETCH;
         end
         S_DROP: begin
            if (i_imem_ack)
               w_state_nxt = S_FETCH;
         end
         default: w_state_nxt = S_FETCH;
      endcase
   end

   // Output logic; the request is masked during the reset cycle
   always_comb begin
      w_req = 1'b0;
      case (r_state)
         S_FETCH: w_req = ~i_stall & ~w_redirect;
         S_WAIT:  w_req = 1'b1;
         S_HOLD:  w_req = 1'b0;
         S_DROP:  w_req = 1'b1;
         default: w_req = 1'b0;
      endcase
      if (i_reset)
         w_req = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pc         <= RESET_PC;
         r_saved_tgt  <= 32'h0;
         r_skid_pc    <= 32'h0;
         r_skid_instr <= 32'h0;
         r_if_pc      <= 32'h0;
         r_if_instr   <= NOP_INSTR;
         r_if_vld     <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               if (w_redirect) begin
                  r_pc       <= w_target;
                  r_if_vld   <= 1'b0;
                  r_if_instr <= NOP_INSTR;
               end else if (w_req && i_imem_ack) begin
                  r_if_pc    <= r_pc;
                  r_if_instr <= i_imem_rdata;
                  r_if_vld   <= 1'b1;
                  r_pc       <= r_pc + 32'd4;
               end else if (!i_stall) begin
                  r_if_vld <= 1'b0;
               end
            end
            S_WAIT: begin
               if (w_redirect) begin
                  r_if_vld   <= 1'b0;
                  r_if_instr <= NOP_INSTR;
                  if (i_imem_ack)
                     r_pc <= w_target;
                  else
                     r_saved_tgt <= w_target;
               end else if (i_imem_ack) begin
                  if (i_stall) begin
                     r_skid_pc    <= r_pc;
                     r_skid_instr <= i_imem_rdata;
                  end else begin
                     r_if_pc    <= r_pc;
                     r_if_instr <= i_imem_rdata;
                     r_if_vld   <= 1'b1;
                     r_pc       <= r_pc + 32'd4;
                  end
               end else if (!i_stall) begin
                  r_if_vld <= 1'b0;
               end
            end
            S_HOLD: begin
               if (w_redirect) begin
                  r_pc       <= w_target;
                  r_if_vld   <= 1'b0;
                  r_if_instr <= NOP_INSTR;
               end else if (!i_stall) begin
                  r_if_pc    <= r_skid_pc;
                  r_if_instr <= r_skid_instr;
                  r_if_vld   <= 1'b1;
                  r_pc       <= r_pc + 32'd4;
               end
            end
            S_DROP: begin
               // Stale data is discarded; the newest redirect target wins
               r_if_vld   <= 1'b0;
               r_if_instr <= NOP_INSTR;
               if (i_imem_ack)
                  r_pc <= w_redirect ? w_target : r_saved_tgt;
               else if (w_redirect)
                  r_saved_tgt <= w_target;
            end
            default: r_pc <= RESET_PC;
         endcase
      end
   end

   assign o_imem_req  = w_req;
   assign o_imem_addr = r_pc;
   assign o_pc        = r_if_pc;
   assign o_pc_four   = r_if_pc + 32'd4;
   assign o_instr     = r_if_instr;
   assign o_instr_vld = r_if_vld;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
//============================================================================
// Module : tb_fetch_stage
// Brief  : Directed self-checking bench for fetch_stage.
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_fetch_stage;

   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        i_pc_sel;
   logic        i_jump;
   logic [31:0] i_alu_data;
   logic        i_stall;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic [31:0] i_imem_rdata;
   logic [31:0] o_pc;
   logic [31:0] o_pc_four;
   logic [31:0] o_instr;
   logic        o_instr_vld;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        o_misalign;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   localparam logic [31:0] NOP = 32'h0000_0013;

   fetch_stage dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_pc_sel     (i_pc_sel),
      .i_jump       (i_jump),
      .i_alu_data   (i_alu_data),
      .i_stall      (i_stall),
      .o_imem_req   (o_imem_req),
      .o_imem_addr  (o_imem_addr),
      .i_imem_ack   (i_imem_ack),
      .i_imem_rdata (i_imem_rdata),
      .o_pc         (o_pc),
      .o_pc_four    (o_pc_four),
      .o_instr      (o_instr),
`ifdef FETCH_MISALIGN_CHECK_EN
      .o_misalign   (o_misalign),
`endif
      .o_instr_vld  (o_instr_vld)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Apply inputs mid-cycle, then let combinational outputs settle
   task automatic drive(input logic pc_sel, input logic jump, input logic [31:0] alu,
                        input logic stall, input logic ack, input logic [31:0] rdata);
      @(negedge i_clk);
      i_pc_sel     = pc_sel;
      i_jump       = jump;
      i_alu_data   = alu;
      i_stall      = stall;
      i_imem_ack   = ack;
      i_imem_rdata = rdata;
      #1;
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   initial begin
      i_reset = 1'b1; i_pc_sel = 1'b0; i_jump = 1'b0; i_alu_data = '0;
      i_stall = 1'b0; i_imem_ack = 1'b0; i_imem_rdata = '0;

      // Reset
      drive(0, 0, 0, 0, 0, 0);
      chk("rst_req", {31'b0, o_imem_req}, 32'd0);
      tick();
      chk("rst_pc", o_pc, 32'h0);
      chk("rst_instr", o_instr, NOP);
      chk("rst_vld", {31'b0, o_instr_vld}, 32'd0);
      i_reset = 1'b0;

      // Zero-latency memory: addresses 0,4,8,12 back to back
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 0, 1, NOP + i);
         chk("seq_req", {31'b0, o_imem_req}, 32'd1);
         chk("seq_addr", o_imem_addr, 32'(4 * i));
         tick();
         chk("seq_pc", o_pc, 32'(4 * i));
         chk("seq_instr", o_instr, NOP + i);
         chk("seq_vld", {31'b0, o_instr_vld}, 32'd1);
      end
      chk("seq_pc4", o_pc_four, 32'd16);

      // Two-cycle latency at 0x8
      drive(0, 1, 32'h8, 0, 0, 0);
      chk("jmp8_req", {31'b0, o_imem_req}, 32'd0);
      tick();
      chk("jmp8_vld", {31'b0, o_instr_vld}, 32'd0);
      drive(0, 0, 0, 0, 0, 0);
      chk("lat_addr0", o_imem_addr, 32'h8);
      tick();
      chk("lat_vld0", {31'b0, o_instr_vld}, 32'd0);
      drive(0, 0, 0, 0, 1, 32'hAAAA_0001);
      chk("lat_addr1", o_imem_addr, 32'h8);
      chk("lat_req1", {31'b0, o_imem_req}, 32'd1);
      tick();
      chk("lat_vld1", {31'b0, o_instr_vld}, 32'd1);
      chk("lat_pc1", o_pc, 32'h8);
      chk("lat_instr1", o_instr, 32'hAAAA_0001);
      drive(0, 0, 0, 0, 0, 0);
      chk("lat_addr2", o_imem_addr, 32'hC);
      tick();
      chk("lat_vld2", {31'b0, o_instr_vld}, 32'd0);
      drive(0, 0, 0, 0, 1, 32'hAAAA_0002);
      tick();
      chk("lat_vld3", {31'b0, o_instr_vld}, 32'd1);
      chk("lat_pc3", o_pc, 32'hC);

      // Redirect while the fetch of 0x20 is outstanding
      drive(0, 1, 32'h20, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk("rw_addr0", o_imem_addr, 32'h20);
      tick();
      drive(1, 0, 32'h100, 0, 0, 0);
      chk("rw_req_redir", {31'b0, o_imem_req}, 32'd1);
      tick();
      chk("rw_vld0", {31'b0, o_instr_vld}, 32'd0);
      drive(0, 0, 0, 0, 0, 0);
      chk("rw_addr_frozen", o_imem_addr, 32'h20);
      chk("rw_req_drop", {31'b0, o_imem_req}, 32'd1);
      tick();
      chk("rw_vld1", {31'b0, o_instr_vld}, 32'd0);
      drive(0, 0, 0, 0, 1, 32'h1234_5678);
      tick();
      chk("rw_vld2", {31'b0, o_instr_vld}, 32'd0);
      chk("rw_instr2", o_instr, NOP);
      drive(0, 0, 0, 0, 0, 0);
      chk("rw_next_addr", o_imem_addr, 32'h100);
      chk("rw_next_req", {31'b0, o_imem_req}, 32'd1);
      tick();
      drive(0, 0, 0, 0, 1, 32'h55);
      tick();
      chk("rw_tgt_pc", o_pc, 32'h100);
      chk("rw_tgt_vld", {31'b0, o_instr_vld}, 32'd1);

      // Stall skid on the ack for 0x40
      drive(0, 1, 32'h40, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk("sk_addr", o_imem_addr, 32'h40);
      tick();
      drive(0, 0, 0, 1, 1, 32'hDEAD_BEEF);
      tick();
      chk("sk_vld_hold0", {31'b0, o_instr_vld}, 32'd0);
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 1, 0, 0);
         chk("sk_req_stall", {31'b0, o_imem_req}, 32'd0);
         tick();
         chk("sk_vld_hold", {31'b0, o_instr_vld}, 32'd0);
      end
      drive(0, 0, 0, 0, 0, 0);
      chk("sk_req_rel", {31'b0, o_imem_req}, 32'd0);
      tick();
      chk("sk_pc", o_pc, 32'h40);
      chk("sk_instr", o_instr, 32'hDEAD_BEEF);
      chk("sk_vld", {31'b0, o_instr_vld}, 32'd1);
      drive(0, 0, 0, 0, 0, 0);
      chk("sk_next_addr", o_imem_addr, 32'h44);
      chk("sk_next_req", {31'b0, o_imem_req}, 32'd1);

      // Stall and jump together while the skid is full
      tick();
      drive(0, 0, 0, 1, 1, 32'hCAFE_F00D);
      tick();
      drive(0, 1, 32'h200, 1, 0, 0);
      chk("hj_req", {31'b0, o_imem_req}, 32'd0);
      tick();
      chk("hj_vld", {31'b0, o_instr_vld}, 32'd0);
      chk("hj_instr", o_instr, NOP);
      drive(0, 0, 0, 0, 0, 0);
      chk("hj_addr", o_imem_addr, 32'h200);
      chk("hj_req2", {31'b0, o_imem_req}, 32'd1);
      tick();

      // Reset while waiting on 0x200, then a late ack
      i_reset = 1'b1;
      drive(0, 0, 0, 0, 1, 32'h0BAD_0BAD);
      chk("rs_req", {31'b0, o_imem_req}, 32'd0);
      tick();
      i_reset = 1'b0;
      chk("rs_vld", {31'b0, o_instr_vld}, 32'd0);
      chk("rs_pc", o_pc, 32'h0);
      drive(0, 0, 0, 1, 1, 32'h0BAD_0BAD);
      chk("rs_late_req", {31'b0, o_imem_req}, 32'd0);
      tick();
      chk("rs_late_vld", {31'b0, o_instr_vld}, 32'd0);
      chk("rs_late_instr", o_instr, NOP);
      drive(0, 0, 0, 0, 0, 0);
      chk("rs_addr", o_imem_addr, 32'h0);
      chk("rs_req2", {31'b0, o_imem_req}, 32'd1);
      tick();
      drive(0, 0, 0, 0, 1, 32'h0000_0093);
      tick();
      chk("rs_fetch_pc", o_pc, 32'h0);
      chk("rs_fetch_instr", o_instr, 32'h0000_0093);

      // PC wrap at the top of the address space
      drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 1, 32'h77);
      chk("wr_addr", o_imem_addr, 32'hFFFF_FFFC);
      tick();
      chk("wr_pc", o_pc, 32'hFFFF_FFFC);
      chk("wr_pc4", o_pc_four, 32'h0);
      drive(0, 0, 0, 0, 0, 0);
      chk("wr_next_addr", o_imem_addr, 32'h0);
      tick();
      drive(0, 0, 0, 0, 1, 32'h13);
      tick();

`ifdef FETCH_MISALIGN_CHECK_EN
      // Misaligned jump target is rounded down and flagged for one cycle
      drive(0, 1, 32'h102, 0, 0, 0);
      tick();
      chk("ma_flag1", {31'b0, o_misalign}, 32'd1);
      drive(0, 0, 0, 0, 0, 0);
      chk("ma_addr", o_imem_addr, 32'h100);
      tick();
      chk("ma_flag0", {31'b0, o_misalign}, 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
